// File: rtl/osc_pkg.sv
// Shared oscillator types: waveform selector and the step-to-sample latency.
package osc_pkg;

  typedef enum logic [1:0] {
    SINE     = 2'd0,
    SQUARE   = 2'd1,
    SAW      = 2'd2,
    TRIANGLE = 2'd3
  } wave_t;

  localparam int OSC_LATENCY = 3;

endpackage

// File: rtl/wavetable_osc_if.sv
// Control/sample bundle for the oscillator; the controller drives master, the oscillator side is slave.
interface wavetable_osc_if #(
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 24
) ();

  logic                      step;
  logic                      sync;
  logic [PHASE_W-1:0]        phase_incr;
  logic [PHASE_W-1:0]        phase_offset;
  logic [1:0]                wave_sel;
  logic signed [OUT_W-1:0]   amp;
  logic                      valid;

  modport master (
    output step, sync, phase_incr, phase_offset, wave_sel,
    input  amp, valid
  );

  modport slave (
    input  step, sync, phase_incr, phase_offset, wave_sel,
    output amp, valid
  );

endinterface

// File: rtl/quarter_sine_rom.sv
// First quadrant of a sine scaled to the signed full-scale maximum, built at elaboration.
// One registered read cycle.
module quarter_sine_rom #(
  parameter int LUT_AW = 10,
  parameter int OUT_W  = 24
) (
  input  logic                    clk,
  input  logic [LUT_AW-3:0]       addr,
  output logic signed [OUT_W-1:0] data
);

  localparam int  DEPTH = 2 ** (LUT_AW - 2);
  localparam real PI    = 3.14159265358979323846;
  localparam real MAXR  = real'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);

  logic signed [OUT_W-1:0] rom [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rom
    // Real-to-integer cast rounds to nearest; all entries are non-negative.
    localparam longint VAL = longint'($sin(real'(i) * PI / real'(2 * DEPTH)) * MAXR);
    assign rom[i] = VAL[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    data <= rom[addr];
  end

endmodule

// File: rtl/wavetable_osc.sv
// Phase-accumulator oscillator producing sine/square/saw/triangle samples.
// Three-stage pipeline: capture phase+offset, ROM read, shape into the output register.
module wavetable_osc
  import osc_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 10,
  parameter int OUT_W   = 24
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    step_in,
  input  logic                    sync_in,
  input  logic [PHASE_W-1:0]      phase_incr_in,
  input  logic [PHASE_W-1:0]      phase_offset_in,
  input  logic [1:0]              wave_sel_in,
  output logic signed [OUT_W-1:0] amp_out,
  output logic                    valid_out
);

  // Only the top KEEP phase bits feed either the ROM address or the shapers.
  localparam int KEEP = (LUT_AW > OUT_W + 1) ? LUT_AW : OUT_W + 1;
  localparam logic signed [OUT_W-1:0] SMAX = {1'b0, {(OUT_W-1){1'b1}}};

  logic [PHASE_W-1:0]      phase;
  logic [PHASE_W-1:0]      p_base;
  logic [PHASE_W-1:0]      p_sum;

  logic                    v1;
  logic [KEEP-1:0]         p1;
  wave_t                   wave1;

  logic                    v2;
  logic [OUT_W:0]          p2;
  wave_t                   wave2;

  logic [LUT_AW-3:0]       rom_addr;
  logic signed [OUT_W-1:0] rom_data;
  logic [OUT_W-1:0]        tri_f;
  logic signed [OUT_W-1:0] shaped;

  // A step coinciding with sync samples from phase 0.
  assign p_base = sync_in ? '0 : phase;
  assign p_sum  = p_base + phase_offset_in;

  if (KEEP < PHASE_W) begin : g_low_sink
    logic unused_low_phase;
    assign unused_low_phase = ^p_sum[PHASE_W-KEEP-1:0];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      phase     <= '0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      valid_out <= 1'b0;
      amp_out   <= '0;
    end else begin
      if (step_in) begin
        phase <= sync_in ? phase_incr_in : phase + phase_incr_in;
      end else if (sync_in) begin
        phase <= '0;
      end
      v1        <= step_in;
      v2        <= v1;
      valid_out <= v2;
      if (v2) begin
        amp_out <= shaped;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    p1    <= p_sum[PHASE_W-1 -: KEEP];
    wave1 <= wave_t'(wave_sel_in);
    p2    <= p1[KEEP-1 -: OUT_W+1];
    wave2 <= wave1;
  end

  // Odd quadrants read the table backwards.
  assign rom_addr = p1[KEEP-2] ? ~p1[KEEP-3 -: LUT_AW-2] : p1[KEEP-3 -: LUT_AW-2];

  quarter_sine_rom #(
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) u_rom (
    .clk  (clk_in),
    .addr (rom_addr),
    .data (rom_data)
  );

  always_comb begin
    shaped = '0;
    tri_f  = p2[OUT_W] ? ~p2[OUT_W-1:0] : p2[OUT_W-1:0];
    case (wave2)
      SINE:     shaped = p2[OUT_W] ? -rom_data : rom_data;
      SQUARE:   shaped = p2[OUT_W] ? -SMAX : SMAX;
      SAW:      shaped = {~p2[OUT_W], p2[OUT_W-1:1]};
      TRIANGLE: shaped = {~tri_f[OUT_W-1], tri_f[OUT_W-2:0]};
      default:  shaped = '0;
    endcase
  end

endmodule

// File: tb/tb_wavetable_osc.sv
// Directed and randomized checks of wavetable_osc against an arithmetic reference model.
module tb_wavetable_osc;
  import osc_pkg::*;

  localparam int PHASE_W = 32;
  localparam int LUT_AW  = 10;
  localparam int OUT_W   = 24;
  localparam real PI     = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wavetable_osc_if #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) bus ();

  wavetable_osc #(
    .PHASE_W (PHASE_W),
    .LUT_AW  (LUT_AW),
    .OUT_W   (OUT_W)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .step_in         (bus.step),
    .sync_in         (bus.sync),
    .phase_incr_in   (bus.phase_incr),
    .phase_offset_in (bus.phase_offset),
    .wave_sel_in     (bus.wave_sel),
    .amp_out         (bus.amp),
    .valid_out       (bus.valid)
  );

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  int steps  = 0;

  logic [PHASE_W-1:0]      m_phase;
  logic signed [OUT_W-1:0] exp_amp;
  logic                    exp_valid;
  int                      due_q[$];
  logic signed [OUT_W-1:0] val_q[$];
  logic signed [OUT_W-1:0] got[$];
  logic signed [OUT_W-1:0] want[$];

  function automatic logic signed [OUT_W-1:0] model(logic [PHASE_W-1:0] p, logic [1:0] w);
    longint half, maxv, r, m, u;
    int q, a, idx, qn;
    half = 64'sd1 <<< (OUT_W - 1);
    maxv = half - 1;
    qn   = 2 ** (LUT_AW - 2);
    r    = 0;
    case (w)
      SINE: begin
        q   = int'(p >> (PHASE_W - 2));
        a   = int'((p >> (PHASE_W - LUT_AW)) % qn);
        idx = (q % 2 == 1) ? qn - 1 - a : a;
        m   = longint'($sin(real'(idx) * PI / real'(2 * qn)) * real'(maxv));
        r   = (q >= 2) ? -m : m;
      end
      SQUARE:  r = p[PHASE_W-1] ? -maxv : maxv;
      SAW:     r = longint'(p >> (PHASE_W - OUT_W)) - half;
      default: begin
        u = longint'(p >> (PHASE_W - 1 - OUT_W)) % (64'sd1 <<< OUT_W);
        if (p[PHASE_W-1]) u = (64'sd1 <<< OUT_W) - 1 - u;
        r = u - half;
      end
    endcase
    return r[OUT_W-1:0];
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: model the launch/phase update, then compare outputs after the edge.
  task automatic tick();
    logic [PHASE_W-1:0] base;
    logic signed [OUT_W-1:0] e;
    if (!rst && bus.step) begin
      base = bus.sync ? '0 : m_phase;
      e = model(base + bus.phase_offset, bus.wave_sel);
      due_q.push_back(edge_n + OSC_LATENCY - 1);
      val_q.push_back(e);
      steps++;
    end
    if (rst)                      m_phase = '0;
    else if (bus.step && bus.sync) m_phase = bus.phase_incr;
    else if (bus.sync)            m_phase = '0;
    else if (bus.step)            m_phase = m_phase + bus.phase_incr;
    @(posedge clk);
    #1;
    if (rst) begin
      due_q.delete();
      val_q.delete();
      exp_valid = 1'b0;
      exp_amp   = '0;
    end else begin
      exp_valid = 1'b0;
      if (due_q.size() > 0 && due_q[0] == edge_n) begin
        void'(due_q.pop_front());
        exp_amp   = val_q.pop_front();
        exp_valid = 1'b1;
      end
    end
    check("valid", 64'(bus.valid), 64'(exp_valid));
    check("amp", 64'(bus.amp), 64'(exp_amp));
    if (bus.valid === 1'b1) got.push_back(bus.amp);
    edge_n++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.step = 1'b0;
    bus.sync = 1'b0;
    tick();
    rst = 1'b0;
    got.delete();
    steps = 0;
  endtask

  task automatic run_steps(int n);
    bus.step = 1'b1;
    for (int i = 0; i < n; i++) tick();
    bus.step = 1'b0;
    for (int i = 0; i < OSC_LATENCY + 1; i++) tick();
  endtask

  task automatic check_want(string tag);
    check({tag, "_count"}, 64'(got.size()), 64'(want.size()));
    for (int i = 0; i < want.size() && i < got.size(); i++)
      check(tag, 64'(got[i]), 64'(want[i]));
    want.delete();
  endtask

  initial begin
    rst = 1'b1;
    bus.step = 1'b0;
    bus.sync = 1'b0;
    bus.phase_incr = '0;
    bus.phase_offset = '0;
    bus.wave_sel = SINE;
    m_phase = '0;
    exp_amp = '0;
    exp_valid = 1'b0;

    do_reset();
    do_reset();
    check("reset_phase", 64'(dut.phase), 64'(0));

    // Sine quadrants
    bus.wave_sel = SINE;
    bus.phase_incr = 32'h4000_0000;
    run_steps(4);
    want = '{24'sd0, 24'sd8388449, 24'sd0, -24'sd8388449};
    check_want("sine");

    // Square
    do_reset();
    bus.wave_sel = SQUARE;
    bus.phase_incr = 32'h2000_0000;
    run_steps(8);
    want = '{24'sd8388607, 24'sd8388607, 24'sd8388607, 24'sd8388607,
             -24'sd8388607, -24'sd8388607, -24'sd8388607, -24'sd8388607};
    check_want("square");

    // Saw
    do_reset();
    bus.wave_sel = SAW;
    bus.phase_incr = 32'h8000_0000;
    run_steps(2);
    want = '{-24'sd8388608, 24'sd0};
    check_want("saw");

    // Triangle
    do_reset();
    bus.wave_sel = TRIANGLE;
    bus.phase_incr = 32'h4000_0000;
    run_steps(3);
    want = '{-24'sd8388608, 24'sd0, 24'sd8388607};
    check_want("triangle");

    // Offset then sync with step
    do_reset();
    bus.wave_sel = SINE;
    bus.phase_offset = 32'h4000_0000;
    bus.phase_incr = 32'h0012_3457;
    bus.step = 1'b1;
    tick();
    bus.sync = 1'b1;
    tick();
    check("phase_after_sync", 64'(dut.phase), 64'(32'h0012_3457));
    bus.sync = 1'b0;
    bus.step = 1'b0;
    for (int i = 0; i < OSC_LATENCY + 1; i++) tick();
    want = '{24'sd8388449, 24'sd8388449};
    check_want("offset_sync");

    // Sync alone clears phase without a sample
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    check("sync_only_phase", 64'(dut.phase), 64'(0));
    for (int i = 0; i < OSC_LATENCY + 1; i++) tick();
    check("sync_only_count", 64'(got.size()), 64'(2));

    // Reset while samples are in flight
    do_reset();
    bus.phase_offset = '0;
    bus.wave_sel = SQUARE;
    bus.step = 1'b1;
    tick();
    tick();
    bus.step = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("inflight_count", 64'(got.size()), 64'(0));
    check("inflight_amp", 64'(bus.amp), 64'(0));

    // Randomized stream with mid-stream wave, increment, offset and sync changes
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.step = ($urandom % 4) != 0;
      bus.sync = ($urandom % 16) == 0;
      if ($urandom % 6 == 0) bus.wave_sel = 2'($urandom % 4);
      if ($urandom % 10 == 0) bus.phase_incr = $urandom;
      if ($urandom % 20 == 0) bus.phase_offset = $urandom;
      tick();
    end
    bus.step = 1'b0;
    bus.sync = 1'b0;
    for (int i = 0; i < OSC_LATENCY + 1; i++) tick();
    check("random_valid_count", 64'(got.size()), 64'(steps));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wavetable_osc.md
WAVETABLE_OSC -- requirements
Module: wavetable_osc

Interface
REQ-001 SHALL have parameter PHASE_W, default 32: phase accumulator width.
REQ-002 SHALL have parameter LUT_AW, default 10: full-wave table address bits, with 4 <= LUT_AW <= PHASE_W.
REQ-003 SHALL have parameter OUT_W, default 24: signed sample width, with 8 <= OUT_W <= 32 and OUT_W + 1 <= PHASE_W.
REQ-004 SHALL have port clk_in, input, 1 bit: the single clock.
REQ-005 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port step_in, input, 1 bit: advances the phase and launches one sample.
REQ-007 SHALL have port sync_in, input, 1 bit: hard-resets the phase to 0.
REQ-008 SHALL have port phase_incr_in, input, PHASE_W bits, unsigned: per-step phase increment.
REQ-009 SHALL have port phase_offset_in, input, PHASE_W bits: added to the phase before waveform lookup.
REQ-010 SHALL have port wave_sel_in, input, 2 bits: 0 SINE, 1 SQUARE, 2 SAW, 3 TRIANGLE.
REQ-011 SHALL have port amp_out, output, OUT_W bits, signed: sample.
REQ-012 SHALL have port valid_out, output, 1 bit: one-cycle pulse marking a new amp_out.

Function
REQ-013 SHALL hold a phase register. On step_in without sync_in: phase <= phase + phase_incr_in, mod 2^PHASE_W.
REQ-014 SHALL, on sync_in without step_in: phase <= 0, and launch no sample.
REQ-015 SHALL, on sync_in and step_in in the same cycle: launch a sample using phase 0, and set phase <= phase_incr_in.
REQ-016 SHALL, on each step, launch a sample computed from p = (pre-update phase + phase_offset_in) mod 2^PHASE_W, using the wave_sel_in value in that cycle.
REQ-017 SHALL be fully pipelined: valid_out asserts exactly 3 cycles after each launching step_in (stages: capture p/wave, ROM read, shape/output register). It SHALL accept step_in every cycle with no stalls.
REQ-018 SHALL hold amp_out between valid_out pulses.
REQ-019 SHALL define MAX = 2^(OUT_W-1) - 1 and MIN = -2^(OUT_W-1).
REQ-020 SHALL use a quarter-wave ROM with 2^(LUT_AW-2) entries, where ROM[i] = round(sin(i*pi/2^(LUT_AW-1)) * MAX), computed at elaboration.
REQ-021 SHALL produce SINE as follows:
- a = p[PHASE_W-3 -: LUT_AW-2], quadrant q = p[PHASE_W-1 -: 2];
- idx = q[0] ? ~a : a;
- amp = q[1] ? -ROM[idx] : ROM[idx].
REQ-022 SHALL produce SQUARE as: p MSB = 0 gives MAX, else MIN+1 (i.e. -MAX).
REQ-023 SHALL produce SAW as: the top OUT_W bits of p with the MSB inverted (phase 0 gives MIN, rising linearly).
REQ-024 SHALL produce TRIANGLE as follows:
- u = p[PHASE_W-2 -: OUT_W];
- f = p MSB ? ~u : u;
- amp = f with its MSB inverted (phase 0 gives MIN, half-phase gives MAX).
REQ-025 SHALL produce every result without overflow or saturation logic: all values lie within [MIN, MAX] by construction.

Reset
REQ-026 SHALL, with rst_in high at a clock edge, clear phase to 0, amp_out to 0, valid_out to 0, and all pipeline valid bits.
REQ-027 SHALL discard samples in flight at reset: no valid_out for them.
REQ-028 SHALL give rst_in priority over step_in and sync_in.

Structure
REQ-029 SHALL take the wave_t enum (SINE, SQUARE, SAW, TRIANGLE) and the 3-cycle latency constant from shared package osc_pkg.
REQ-030 SHALL place the quarter-wave ROM in sub-module quarter_sine_rom (parameters LUT_AW and OUT_W), with a registered 1-cycle read.

Verification (defaults PHASE_W=32, LUT_AW=10, OUT_W=24)
REQ-031 SHALL cover SINE: incr 2^30, offset 0, four consecutive steps -> amp 0, 8388449, 0, -8388449, each 3 cycles after its step.
REQ-032 SHALL cover SQUARE: incr 2^29, eight steps -> four samples of 8388607, then four of -8388607.
REQ-033 SHALL cover SAW and TRIANGLE:
- SAW at p = 0 -> -8388608; at p = 2^31 -> 0;
- TRIANGLE at p = 0, 2^30, 2^31 -> -8388608, 0, 8388607.
REQ-034 SHALL cover offset and sync: SINE, offset 2^30, first step after reset -> 8388449; then sync_in with step_in -> next sample 8388449, phase register = incr.
REQ-035 SHALL cover reset in flight: steps on two consecutive cycles, rst_in on the following cycle -> valid_out stays 0 and amp_out = 0.
REQ-036 SHALL cover mid-stream wave_sel change: the switch affects only samples launched after it; valid_out count equals step count.
